// File: rtl/axi4l_slv.sv
// axi4l_slv: AXI4-Lite slave register bank with byte strobes, configurable
// response latency, handshake counters and a sticky decode-error flag.
module axi4l_slv #(
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int          NUM_REGS   = 16,
   parameter int          WR_LATENCY = 0,
   parameter int          RD_LATENCY = 0
) (
   input  logic        axi_aclk,
   input  logic        axi_areset,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [31:0] wr_count,
   output logic [31:0] rd_count,
   output logic        error
);
   localparam int          IW     = $clog2(NUM_REGS);
   localparam logic [31:0] SPAN   = 32'(NUM_REGS * 4);
   localparam logic [3:0]  WL     = 4'(WR_LATENCY);
   localparam logic [3:0]  RL     = 4'(RD_LATENCY);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_EXEC, W_LAT, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} r_state_t;

   // Offset is modular, so addresses below the base wrap high and miss.
   function automatic logic hit(input logic [31:0] a);
      return (a - ADDR_BASE) < SPAN;
   endfunction

   function automatic logic [IW-1:0] idx(input logic [31:0] a);
      return IW'((a - ADDR_BASE) >> 2);
   endfunction

   w_state_t    w_state, w_next;
   r_state_t    r_state, r_next;
   logic [31:0] regs [NUM_REGS];
   logic [31:0] aw_addr, wdata_q, ar_addr, rd_addr;
   logic [3:0]  wstrb_q, w_cnt, r_cnt;
   logic        aw_done, w_done, aw_done_d, w_done_d;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic        wr_en, rd_load;
   logic        unused_ok;

   assign unused_ok = ^{s_axi_awprot, s_axi_arprot};
   assign aw_hs     = s_axi_awvalid & s_axi_awready;
   assign w_hs      = s_axi_wvalid & s_axi_wready;
   assign b_hs      = s_axi_bvalid & s_axi_bready;
   assign ar_hs     = s_axi_arvalid & s_axi_arready;
   assign r_hs      = s_axi_rvalid & s_axi_rready;
   assign aw_done_d = !b_hs && (aw_done || aw_hs);
   assign w_done_d  = !b_hs && (w_done || w_hs);

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_done_d && w_done_d) w_next = W_EXEC;
         W_EXEC:  w_next = (WL == 4'd0) ? W_RESP : W_LAT;
         W_LAT:   if (w_cnt == 4'd1) w_next = W_RESP;
         W_RESP:  if (s_axi_bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs) r_next = (RL == 4'd0) ? R_RESP : R_LAT;
         R_LAT:   if (r_cnt == 4'd1) r_next = R_RESP;
         R_RESP:  if (s_axi_rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      s_axi_bvalid = (w_state == W_RESP);
      s_axi_rvalid = (r_state == R_RESP);
      wr_en        = (w_state == W_EXEC) && hit(aw_addr);
      rd_load      = (r_next == R_RESP) && (r_state != R_RESP);
      rd_addr      = (r_state == R_IDLE) ? s_axi_araddr : ar_addr;
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         aw_addr       <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         w_cnt         <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bresp   <= OKAY;
         wr_count      <= '0;
      end else begin
         aw_done       <= aw_done_d;
         w_done        <= w_done_d;
         s_axi_awready <= (w_next == W_IDLE) && !aw_done_d;
         s_axi_wready  <= (w_next == W_IDLE) && !w_done_d;
         if (aw_hs) aw_addr <= s_axi_awaddr;
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         if (w_state == W_EXEC) begin
            w_cnt       <= WL;
            s_axi_bresp <= hit(aw_addr) ? OKAY : SLVERR;
         end else if (w_state == W_LAT) begin
            w_cnt <= w_cnt - 4'd1;
         end
         if (b_hs) wr_count <= wr_count + 32'd1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         ar_addr       <= '0;
         r_cnt         <= '0;
         s_axi_arready <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= OKAY;
         rd_count      <= '0;
      end else begin
         s_axi_arready <= (r_next == R_IDLE);
         if (ar_hs) begin
            ar_addr <= s_axi_araddr;
            r_cnt   <= RL;
         end else if (r_state == R_LAT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (rd_load) begin
            s_axi_rdata <= hit(rd_addr) ? regs[idx(rd_addr)] : 32'd0;
            s_axi_rresp <= hit(rd_addr) ? OKAY : SLVERR;
         end
         if (r_hs) rd_count <= rd_count + 32'd1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) regs[idx(aw_addr)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset)
         error <= 1'b0;
      else if ((b_hs && s_axi_bresp == SLVERR) || (r_hs && s_axi_rresp == SLVERR))
         error <= 1'b1;
   end
endmodule

// File: tb/tb_axi4l_slv.sv
// tb_axi4l_slv: directed vector table plus hand-written handshake ordering,
// read-stall and mid-transaction reset sequences for the register bank.
module tb_axi4l_slv;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int NV = 14;

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, error;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, wr_count, rd_count;

   int   cyc = 0, errs = 0, checks = 0, bv_rises = 0;
   logic bv_prev = 1'b0;

   axi4l_slv #(
      .ADDR_BASE(BASE), .NUM_REGS(16), .WR_LATENCY(0), .RD_LATENCY(3)
   ) dut (
      .axi_aclk(clk), .axi_areset(rst),
      .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .wr_count(wr_count), .rd_count(rd_count), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      bv_prev <= bvalid;
      if (bvalid && !bv_prev) bv_rises <= bv_rises + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_b(input int c_hs, input bit chk_w,
                         output logic [1:0] r, output int lat);
      int n = 0;
      while (!bvalid && n < 40) begin
         if (chk_w) check("wready_low", 32'(wready), 32'd0);
         @(negedge clk);
         n++;
      end
      check("bvalid_seen", 32'(bvalid), 32'd1);
      lat = cyc - c_hs;
      r   = bresp;
      @(negedge clk);
      check("bvalid_hold", 32'({bvalid, bresp}), 32'({1'b1, r}));
      if (chk_w) check("wready_low", 32'(wready), 32'd0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r, output int lat);
      int c_hs = 0, n = 0;
      bit aw_f, w_f, aw_ok = 0, w_ok = 0;
      @(negedge clk);
      awaddr = a; awvalid = 1'b1;
      wdata = d; wstrb = s; wvalid = 1'b1;
      while (!(aw_ok && w_ok) && n < 40) begin
         aw_f = awvalid && awready;
         w_f  = wvalid && wready;
         if (aw_f || w_f) c_hs = cyc;
         @(negedge clk);
         n++;
         if (aw_f) begin awvalid = 1'b0; aw_ok = 1; end
         if (w_f) begin wvalid = 1'b0; w_ok = 1; end
      end
      check("aw_w_accepted", 32'({aw_ok, w_ok}), 32'd3);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wait_b(c_hs, 1'b0, r, lat);
   endtask

   task automatic do_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r, output int lat);
      int c_hs, n = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      while (!arready && n < 40) begin @(negedge clk); n++; end
      check("arready_seen", 32'(arready), 32'd1);
      c_hs = cyc;
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 40) begin @(negedge clk); n++; end
      check("rvalid_seen", 32'(rvalid), 32'd1);
      lat = cyc - c_hs;
      d = rdata;
      r = rresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rdata_hold", rdata, d);
         check("rresp_hold", 32'({rvalid, rresp}), 32'({1'b1, r}));
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_drop", 32'(rvalid), 32'd0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t        tbl [NV];
   logic [1:0]  resp;
   logic [31:0] rd;
   int          lat, c, n, exp_wr, exp_rd, n_writes;
   logic        exp_err;

   initial begin
      tbl[0]  = '{1'b1, BASE + 32'h04, 32'hDEADBEEF, 4'hF,    2'b00, 32'h0};
      tbl[1]  = '{1'b0, BASE + 32'h04, 32'h0,        4'h0,    2'b00, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, BASE + 32'h04, 32'h11223344, 4'b0101, 2'b00, 32'h0};
      tbl[3]  = '{1'b0, BASE + 32'h04, 32'h0,        4'h0,    2'b00, 32'hDE22BE44};
      tbl[4]  = '{1'b1, BASE + 32'h40, 32'hCAFEF00D, 4'hF,    2'b10, 32'h0};
      tbl[5]  = '{1'b0, BASE + 32'h40, 32'h0,        4'h0,    2'b10, 32'h0};
      tbl[6]  = '{1'b0, BASE,          32'h0,        4'h0,    2'b00, 32'h0};
      tbl[7]  = '{1'b1, BASE + 32'h3F, 32'h0A0B0C0D, 4'hF,    2'b00, 32'h0};
      tbl[8]  = '{1'b0, BASE + 32'h3C, 32'h0,        4'h0,    2'b00, 32'h0A0B0C0D};
      tbl[9]  = '{1'b1, BASE - 32'h04, 32'h12345678, 4'hF,    2'b10, 32'h0};
      tbl[10] = '{1'b0, BASE + 32'h3C, 32'h0,        4'h0,    2'b00, 32'h0A0B0C0D};
      tbl[11] = '{1'b1, BASE + 32'h08, 32'hAABBCCDD, 4'b1000, 2'b00, 32'h0};
      tbl[12] = '{1'b0, BASE + 32'h08, 32'h0,        4'h0,    2'b00, 32'hAA000000};
      tbl[13] = '{1'b0, 32'h0000_0004, 32'h0,        4'h0,    2'b10, 32'h0};
      exp_wr = 0; exp_rd = 0; n_writes = 0; exp_err = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_readies_valids", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
      check("rst_resp_err", 32'({bresp, rresp, error}), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_counts", wr_count | rd_count, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'({awready, wready, arready}), 32'd7);

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, resp, lat);
            exp_wr++; n_writes++;
            check($sformatf("v%0d_bresp", i), 32'(resp), 32'(tbl[i].resp));
            check($sformatf("v%0d_blat", i), 32'(lat), 32'd2);
         end else begin
            do_read(tbl[i].addr, 1, rd, resp, lat);
            exp_rd++;
            check($sformatf("v%0d_rresp", i), 32'(resp), 32'(tbl[i].resp));
            check($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
            check($sformatf("v%0d_rlat", i), 32'(lat), 32'd4);
         end
         if (tbl[i].resp == 2'b10) exp_err = 1'b1;
         check($sformatf("v%0d_wr_count", i), wr_count, 32'(exp_wr));
         check($sformatf("v%0d_rd_count", i), rd_count, 32'(exp_rd));
         check($sformatf("v%0d_error", i), 32'(error), 32'(exp_err));
      end

      // W accepted three cycles before AW; wready must stay low until B.
      @(negedge clk);
      wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      check("wfirst_wready", 32'(wready), 32'd1);
      c = cyc;
      @(negedge clk);
      wvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("wfirst_wready_low", 32'(wready), 32'd0);
         check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
         @(negedge clk);
      end
      check("wfirst_gap", 32'(cyc - c), 32'd3);
      awaddr = BASE + 32'h10; awvalid = 1'b1;
      check("wfirst_awready", 32'(awready), 32'd1);
      check("wfirst_wready_low", 32'(wready), 32'd0);
      c = cyc;
      @(negedge clk);
      awvalid = 1'b0;
      wait_b(c, 1'b1, resp, lat);
      exp_wr++; n_writes++;
      check("wfirst_bresp", 32'(resp), 32'd0);
      check("wfirst_blat", 32'(lat), 32'd2);

      do_write(BASE + 32'h14, 32'h5A5A_0002, 4'hF, resp, lat);
      exp_wr++; n_writes++;
      check("same_cycle_blat", 32'(lat), 32'd2);
      check("bvalid_one_per_write", 32'(bv_rises), 32'(n_writes));
      check("wr_count_seq", wr_count, 32'(exp_wr));

      do_read(BASE + 32'h10, 1, rd, resp, lat);
      exp_rd++;
      check("wfirst_readback", rd, 32'hCAFE0001);

      // Master stalls rready for five cycles after rvalid.
      do_read(BASE + 32'h04, 5, rd, resp, lat);
      exp_rd++;
      check("stall_rlat", 32'(lat), 32'd4);
      check("stall_rdata", rd, 32'hDE22BE44);
      check("stall_rresp", 32'(resp), 32'd0);
      @(negedge clk);
      check("stall_rd_count", rd_count, 32'(exp_rd));
      check("error_sticky", 32'(error), 32'd1);

      // Reset between the AW and W handshakes.
      awaddr = BASE + 32'h04; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      check("mid_awready", 32'(awready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_readies_valids", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
      check("mid_rst_resp_err", 32'({bresp, rresp, error}), 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      check("mid_rst_counts", wr_count | rd_count, 32'd0);
      exp_wr = 0; exp_rd = 0;

      do_read(BASE + 32'h08, 1, rd, resp, lat);
      exp_rd++;
      check("mid_array_zeroed", rd, 32'd0);
      do_write(BASE + 32'h0C, 32'h55AA_33CC, 4'hF, resp, lat);
      exp_wr++;
      check("mid_bresp", 32'(resp), 32'd0);
      do_read(BASE + 32'h0C, 1, rd, resp, lat);
      exp_rd++;
      check("mid_readback", rd, 32'h55AA_33CC);
      @(negedge clk);
      check("mid_wr_count", wr_count, 32'(exp_wr));
      check("mid_rd_count", rd_count, 32'(exp_rd));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/axi4l_slv.md
# axi4l_slv

Simulation-grade AXI4-Lite slave register bank: the responder counterpart to the team's scenario-driven AXI4-Lite master. It decodes a window of `NUM_REGS` 32-bit registers at `ADDR_BASE`, honours byte strobes, and inserts configurable write and read response latency. It counts completed transactions and flags decode errors, so master-side scenario runs can be checked end-to-end without a real peripheral.

## Interface
- `ADDR_BASE`, default `32'h0000_0000`: byte address of register 0; must be aligned to `NUM_REGS*4`.
- `NUM_REGS`, default `16`: number of registers; power of two, 2..256.
- `WR_LATENCY`, default `0`: extra cycles (0..15) between the register write and `bvalid`.
- `RD_LATENCY`, default `0`: extra cycles (0..15) between the AR handshake and `rvalid`.

Ports:
- `axi_aclk` in 1: sole clock; all logic on its rising edge.
- `axi_areset` in 1: synchronous, active-high reset.
- AW channel: `s_axi_awaddr` in 32, `s_axi_awprot` in 3 (ignored), `s_axi_awvalid` in 1, `s_axi_awready` out 1.
- W channel: `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1.
- B channel: `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1.
- AR channel: `s_axi_araddr` in 32, `s_axi_arprot` in 3 (ignored), `s_axi_arvalid` in 1, `s_axi_arready` out 1.
- R channel: `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1.
- `wr_count` out 32: completed B handshakes; wraps.
- `rd_count` out 32: completed R handshakes; wraps.
- `error` out 1: sticky; set on any SLVERR handshake.

## Operation
- Decode: `offset = addr - ADDR_BASE` (32-bit modular). Hit if `offset < NUM_REGS*4`. Index = `offset[log2(NUM_REGS)+1:2]`; `addr[1:0]` ignored. Miss produces SLVERR (`2'b10`). Hit produces OKAY (`2'b00`).
- Write FSM states:
  - W_IDLE: `awready`/`wready` are registered. Each is 1 while its channel is not yet captured. AW and W are captured independently, in either order or the same cycle. Each ready drops the cycle after its own handshake.
  - W_EXEC: entered once both channels are captured. On a hit, the array is written per byte lane (`wstrb[i]` enables bits `8i+7:8i`); a miss leaves the array unchanged. Latency counter loads `WR_LATENCY`.
  - W_LAT: counts down to 0.
  - W_RESP: `bvalid`=1 and `bresp` stable until `bready`. On the handshake, `wr_count` increments, `error` is set if SLVERR, and the FSM returns to W_IDLE with both readies re-raised next cycle.
- Read FSM states:
  - R_IDLE: `arready`=1. On the handshake, capture the address; `arready` drops next cycle.
  - R_LAT: counts `RD_LATENCY` cycles.
  - R_RESP: `rdata` (array word on a hit, 0 on a miss) and `rresp` are loaded on entry and held with `rvalid`=1 until `rready`. On the handshake, `rd_count` increments, `error` is set if SLVERR, and the FSM returns to R_IDLE.
- Read and write paths are fully concurrent. If the array write and the `rdata` load to the same index land on the same edge, `rdata` takes the old value.
- Only one outstanding transaction per direction.

## Timing
- Reset values, applied on any edge with `axi_areset`=1, including mid-transaction:
  - All readies and valids are 0.
  - `bresp`, `rresp`, `rdata`, `wr_count`, `rd_count` and `error` are 0.
  - All register array entries are 0.
  - Both FSMs return to idle, and partial captures are discarded.
  - Readies rise in the first cycle after reset deasserts.
- Write latency: let c be the cycle of the later of the AW and W handshakes. W_EXEC occurs in c+1. `bvalid` is first high in cycle c+2+`WR_LATENCY`.
- Read latency: let c be the AR handshake cycle. `rvalid` is first high in cycle c+1+`RD_LATENCY`.
- A master that raises `bready`/`rready` one cycle after seeing valid must work. Valid and payload never change while valid=1 and ready=0.
- Counters wrap from `32'hFFFF_FFFF` to 0 with no flag.

## Test plan
- Write `32'hDEADBEEF` to `ADDR_BASE+4` with `wstrb`=`4'hF`, then read it back. Required: `bresp`=0, `rdata`=`32'hDEADBEEF`, `rresp`=0, `wr_count`=1, `rd_count`=1.
- Partial strobe: with `32'hDEADBEEF` already in the register, write `32'h11223344` with `wstrb`=`4'b0101`. Required: read returns `32'hDE22BE44`.
- W handshake 3 cycles before AW; second write with AW and W in the same cycle. Required: exactly one `bvalid` per write; `wready` stays low from the W handshake until the B handshake; `bvalid` at c+2 with `WR_LATENCY`=0.
- Write and read at `ADDR_BASE + NUM_REGS*4`. Required: `bresp`=`2'b10`, `rresp`=`2'b10`, `rdata`=0, `error`=1 and sticky through later OKAY transfers; array unchanged.
- With `RD_LATENCY`=3 and `rready` held low 5 cycles after valid. Required: `rvalid` first high at c+4; `rdata` and `rresp` stable until the handshake; `rd_count` increments exactly once.
- Assert `axi_areset` for 1 cycle after the AW handshake but before W. Required: all outputs at reset values and the array zeroed; a following complete write/read pair succeeds with `wr_count`=1.
